// File: rtl/common.sv
// Common scalar types shared across the execute-side blocks.
package common;

  typedef logic [63:0] u64;

endpackage : common

// File: rtl/pipes.sv
// Pipeline-facing types: ALU operation encodings and the request bundle.
package pipes;

  import common::*;

  // Default tag width for users that do not parameterise their own request type.
  localparam int REQ_TAG_W = 4;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLTI  = 5'd8,
    ALU_SLTIU = 5'd9,
    ALU_ADDW  = 5'd10,
    ALU_SUBW  = 5'd11,
    ALU_SLLW  = 5'd12,
    ALU_SRLW  = 5'd13,
    ALU_SRAW  = 5'd14
  } alufunc_t;

  typedef struct packed {
    u64                   a;
    u64                   b;
    alufunc_t             func;
    logic [REQ_TAG_W-1:0] tag;
  } alu_req_t;

endpackage : pipes

// File: rtl/alu.sv
// Combinational 64-bit ALU; W variants operate on the low word and sign-extend.
module alu
  import common::*;
  import pipes::*;
(
  input  u64       a,
  input  u64       b,
  input  alufunc_t func,
  output u64       c
);

  logic [31:0] w_res;

  // Word result computed once, then sign-extended for every W operation.
  always_comb begin
    w_res = '0;
    case (func)
      ALU_ADDW: w_res = a[31:0] + b[31:0];
      ALU_SUBW: w_res = a[31:0] - b[31:0];
      ALU_SLLW: w_res = a[31:0] << b[4:0];
      ALU_SRLW: w_res = a[31:0] >> b[4:0];
      ALU_SRAW: w_res = 32'($signed(a[31:0]) >>> b[4:0]);
      default:  w_res = '0;
    endcase
  end

  // Final result select; unrecognised encodings forward operand b.
  always_comb begin
    c = b;
    case (func)
      ALU_ADD:   c = a + b;
      ALU_SUB:   c = a - b;
      ALU_AND:   c = a & b;
      ALU_OR:    c = a | b;
      ALU_XOR:   c = a ^ b;
      ALU_SLL:   c = a << b[5:0];
      ALU_SRL:   c = a >> b[5:0];
      ALU_SRA:   c = u64'($signed(a) >>> b[5:0]);
      ALU_SLTI:  c = {63'd0, ($signed(a) < $signed(b))};
      ALU_SLTIU: c = {63'd0, (a < b)};
      ALU_ADDW,
      ALU_SUBW,
      ALU_SLLW,
      ALU_SRLW,
      ALU_SRAW:  c = {{32{w_res[31]}}, w_res};
      default:   c = b;
    endcase
  end

endmodule : alu

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a
// single registered valid/ready result stage tagged by requester id and tag.
module alu_arbiter
  import common::*;
  import pipes::*;
#(
  parameter  int NREQ  = 2,
  parameter  int TAG_W = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][63:0]      req_a,
  input  logic [NREQ-1:0][63:0]      req_b,
  input  alufunc_t [NREQ-1:0]        req_func,
  input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_c,
  output logic [IDW-1:0]             out_id,
  output logic [TAG_W-1:0]           out_tag
);

  // Request bundle carrying this instance's tag width.
  typedef struct packed {
    u64               a;
    u64               b;
    alufunc_t         func;
    logic [TAG_W-1:0] tag;
  } req_t;

  // Search from ptr+1 upward with wrap; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!res[IDW] && valid[idx]) begin
        res = {1'b1, IDW'(idx)};
      end
    end
    return res;
  endfunction

  logic             out_valid_q, out_valid_d;
  u64               out_c_q,     out_c_d;
  logic [IDW-1:0]   out_id_q,    out_id_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;

  logic             can_accept;
  logic [IDW:0]     pick;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic             xfer;
  req_t             sel_req;
  u64               alu_c;

  // Grant decision: depends on req_valid, out_ready and registered state only.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    pick       = rr_pick(req_valid, rr_ptr_q);
    grant_vld  = !reset && can_accept && pick[IDW];
    grant_id   = pick[IDW-1:0];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_vld && (grant_id == IDW'(gi));
  end

  assign xfer = |(req_valid & req_ready);

  // Steer the winning requester's operands into the shared ALU.
  always_comb begin
    sel_req.a    = req_a[grant_id];
    sel_req.b    = req_b[grant_id];
    sel_req.func = req_func[grant_id];
    sel_req.tag  = req_tag[grant_id];
  end

  alu u_alu (
    .a    (sel_req.a),
    .b    (sel_req.b),
    .func (sel_req.func),
    .c    (alu_c)
  );

  // Output stage: load on transfer (no bubble), drain when consumed, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_id_d    = out_id_q;
    out_tag_d   = out_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_c_d     = alu_c;
      out_id_d    = grant_id;
      out_tag_d   = sel_req.tag;
      rr_ptr_d    = grant_id;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset leaves the last requester as previous winner so 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_id_q    <= '0;
      out_tag_q   <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_id_q    <= out_id_d;
      out_tag_q   <= out_tag_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_id    = out_id_q;
  assign out_tag   = out_tag_q;

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` datapath instance between NREQ execute-side requesters, for example the main execute lane and the address/branch-compare lane.
- Each cycle it picks at most one requester with a round-robin policy and drives that requester's operands and alufunc into the ALU.
- The result is registered into a single output stage with a valid/ready handshake, tagged with the winning requester id and that requester's tag.
- Sits in the execute stage between the decode/issue registers and the memory-stage pipeline register.

Parameters:
NREQ, 2, number of requesters (2..4); id width IDW = $clog2(NREQ), minimum 1
TAG_W, 4, width of the opaque per-request tag returned with the result

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  request pending, one bit per requester
req_ready  output  NREQ  grant/accept, one-hot or zero
req_a  input  NREQ x 64 (u64)  operand a per requester
req_b  input  NREQ x 64 (u64)  operand b per requester
req_func  input  NREQ x alufunc_t  ALU operation per requester
req_tag  input  NREQ x TAG_W  opaque tag per requester
out_valid  output  1  registered result valid
out_ready  input  1  downstream accepts result
out_c  output  64 (u64)  registered ALU result
out_id  output  IDW  index of the requester that produced out_c
out_tag  output  TAG_W  tag of that request

Behaviour:
- Reset (synchronous, active-high; clk/reset as above): out_valid=0, out_c=0, out_id=0, out_tag=0, rr_ptr=NREQ-1. Requester 0 therefore has first priority after reset.
- req_ready is combinational: 0 for all requesters during reset.
- can_accept = !out_valid || out_ready.
- Grant:
  - if can_accept, search requesters starting at (rr_ptr+1) mod NREQ and wrapping; the first with req_valid=1 wins.
  - req_ready[win]=1; all other req_ready bits are 0.
  - if !can_accept or no valid request, req_ready=0.
- req_ready must not depend on req_ready; it may depend on req_valid and out_ready.
- Transfer: occurs when req_valid[i] && req_ready[i] at a rising edge. On transfer:
  - out_c <= alu(req_a[win], req_b[win], req_func[win])
  - out_id <= win; out_tag <= req_tag[win]; out_valid <= 1; rr_ptr <= win.
- Latency is exactly 1 cycle from the accept edge to out_valid=1. Throughput is 1 result per cycle while out_ready=1.
- Output handshake:
  - if out_valid && out_ready and there is no new transfer, out_valid <= 0.
  - if there is a new transfer in the same cycle, the output is replaced with no bubble.
- Backpressure: while out_valid && !out_ready, out_c, out_id and out_tag hold stable, no grants are issued, and rr_ptr holds.
- Requester rule: once req_valid is asserted, req_a, req_b, req_func and req_tag stay stable until accepted. This is not checked in RTL; it is a bench assertion.
- The arbiter does not drop a pending request. A requester may deassert req_valid only after acceptance.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,..,NREQ-1,0 with no requester waiting more than NREQ-1 accepts.
- Single requester: if only one requester is valid, it is granted every cycle, regardless of rr_ptr.
- ALU semantics (combinational, all 64-bit):
  - W variants sign-extend bit 31.
  - shifts use b[5:0], or b[4:0] for W variants.
  - SLTI/SLTIU produce 0/1 in bit 0.
  - an unknown func passes b.
- Reset mid-operation: any held result is discarded, out_valid=0 on the next cycle, and rr_ptr is restored to NREQ-1.
- No combinational path from req_* to out_* ports. All outputs except req_ready are flops.

Decomposition:
- Package pipes: alufunc_t and its ALU_* encodings (already present); add typedef alu_req_t {u64 a; u64 b; alufunc_t func; logic [TAG_W-1:0] tag;}.
- Package common: u64.
- Sub-module: the existing `alu` module, instantiated once and fed by the granted request mux.
- Round-robin pick logic lives inside alu_arbiter as a function; no separate module.

Test Plan:
- Reset then req0 only, ADD a=3 b=4 tag=5 -> next cycle out_valid=1, out_c=7, out_id=0, out_tag=5.
- Both valid continuously after reset, out_ready=1: req0 SUB 10-3, req1 XOR 0xF0^0xFF -> results alternate 7 (id0), 0x0F (id1), 7, 0x0F; one result per cycle.
- Backpressure with req1 ADDW a=0x7FFFFFFF b=1:
  - hold out_ready=0 for 3 cycles -> out_c=0xFFFFFFFF80000000 stable, req_ready=0 throughout.
  - then out_ready=1 -> next request accepted in that same cycle.
- SRAW a=0x00000000_80000000 b=0x21 -> out_c=0xFFFFFFFF_C0000000 (shift by 1). SLTI a=-1 b=0 -> out_c=1.
- Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0. Both requesters valid after reset -> req0 granted first.
- Single requester req1 valid for 4 cycles with out_ready=1 -> granted every cycle, out_id=1 four times, no idle cycles.
